// File: rtl/bus_txn_master.sv
// Single-outstanding valid/ready bus master fed by a small command FIFO.
// Optional watchdog on the bus request is enabled with `define BUS_TIMEOUT_EN.
module bus_txn_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_wr_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
  logic [ENT_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_fresh_q, head_fresh_d;
  logic             push, pop;

  logic              bus_valid_q, bus_valid_d;
  logic              bus_wr_en_q, bus_wr_en_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign head_wr    = head_q[ENT_W-1];
  assign head_addr  = head_q[ENT_W-2 -: ADDR_W];
  assign head_wdata = head_q[DATA_W-1:0];

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;

  // Storage has no reset so it maps onto block RAM; the head is read through a register.
  assign head_d = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
    head_q <= head_d;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A head slot written this edge is not yet visible through the registered read.
    head_fresh_d = push && (wr_ptr_q == rd_ptr_d);
  end

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    bus_valid_d = bus_valid_q;
    bus_wr_en_d = bus_wr_en_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef BUS_TIMEOUT_EN
    wait_d      = wait_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !head_fresh_q) begin
          pop         = 1'b1;
          bus_valid_d = 1'b1;
          bus_wr_en_d = head_wr;
          bus_addr_d  = head_addr;
          bus_wdata_d = head_wr ? head_wdata : '0;
          state_d     = ISSUE;
`ifdef BUS_TIMEOUT_EN
          wait_d      = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          bus_wr_en_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = bus_wr_en_q;
          rsp_addr_d  = bus_addr_q;
          rsp_rdata_d = bus_wr_en_q ? '0 : bus_rdata;
          state_d     = RESP;
`ifdef BUS_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          bus_valid_d = 1'b0;
          bus_wr_en_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = bus_wr_en_q;
          rsp_addr_d  = bus_addr_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d      = wait_q + WAIT_W'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_fresh_q <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_wr_en_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_wr_q     <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
      wait_q       <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_fresh_q <= head_fresh_d;
      bus_valid_q  <= bus_valid_d;
      bus_wr_en_q  <= bus_wr_en_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef BUS_TIMEOUT_EN
      wait_q       <= wait_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_wr_en = bus_wr_en_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_txn_master.sv
// Directed bench for bus_txn_master: behavioural slave memory plus a response log.
module tb_bus_txn_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        bus_valid, bus_ready, bus_wr_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [7:0]  rsp_addr;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t rsp_log[$];

  logic [31:0] smem [256];

  always #5 clk = ~clk;

  bus_txn_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_wr_en (bus_wr_en),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  assign bus_rdata = smem[bus_addr];

  always @(posedge clk) begin
    if (bus_valid && bus_ready && bus_wr_en) smem[bus_addr] <= bus_wdata;
  end

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rsp_log.push_back('{rsp_wr, rsp_addr, rsp_rdata, rsp_err});
      $display("rsp wr=%0d addr=0x%02h rdata=0x%08h err=%0d", rsp_wr, rsp_addr, rsp_rdata, rsp_err);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bus(input string tag);
    int n = 0;
    while (!bus_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(bus_valid), 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_rsp(input string tag, input int idx, input logic wr, input logic [7:0] addr,
                           input logic [31:0] rdata, input logic err);
    if (idx < rsp_log.size()) begin
      check({tag, "_wr"},    64'(rsp_log[idx].wr),    64'(wr));
      check({tag, "_addr"},  64'(rsp_log[idx].addr),  64'(addr));
      check({tag, "_rdata"}, 64'(rsp_log[idx].rdata), 64'(rdata));
      check({tag, "_err"},   64'(rsp_log[idx].err),   64'(err));
    end else begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    bus_ready = 1'b1;
    rsp_ready = 1'b1;
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_bus_addr",  64'(bus_addr),  64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Write then read back the same word through a zero-wait slave.
    rsp_log.delete();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hA5A5_0001;
    tick();
    check("t1_lat0", 64'(bus_valid), 64'd0);
    cmd_wr = 1'b0; cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    check("t1_lat1", 64'(bus_valid), 64'd0);
    tick();
    check("t1_lat2_valid", 64'(bus_valid), 64'd1);
    check("t1_wr_en",      64'(bus_wr_en), 64'd1);
    check("t1_addr",       64'(bus_addr),  64'h10);
    check("t1_wdata",      64'(bus_wdata), 64'hA5A5_0001);
    repeat (15) tick();
    check("t1_count", 64'(rsp_log.size()), 64'd2);
    check_rsp("t1_w", 0, 1'b1, 8'h10, 32'h0, 1'b0);
    check_rsp("t1_r", 1, 1'b0, 8'h10, 32'hA5A5_0001, 1'b0);

    // Back-to-back pushes against a stalled slave fill the FIFO.
    rsp_log.delete();
    bus_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b1;
      cmd_addr  = 8'h30 + 8'(i);
      cmd_wdata = 32'hB000_0000 + 32'(i);
      check($sformatf("t2_ready%0d", i), 64'(cmd_ready), (i < 5) ? 64'd1 : 64'd0);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("t2_hold_valid", 64'(bus_valid), 64'd1);
    check("t2_hold_addr",  64'(bus_addr),  64'h30);
    bus_ready = 1'b1;
    repeat (30) tick();
    check("t2_count", 64'(rsp_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check_rsp($sformatf("t2_%0d", i), i, 1'b1, 8'h30 + 8'(i), 32'h0, 1'b0);
    end

    // Three slave wait states on a write to the top address.
    rsp_log.delete();
    bus_ready = 1'b0;
    push(1'b1, 8'hFF, 32'h1234_5678);
    wait_bus("t3_issue");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_valid%0d", k), 64'(bus_valid), 64'd1);
      check($sformatf("t3_addr%0d", k),  64'(bus_addr),  64'hFF);
      check($sformatf("t3_wdata%0d", k), 64'(bus_wdata), 64'h1234_5678);
      if (k == 3) bus_ready = 1'b1;
      tick();
    end
    check("t3_drop", 64'(bus_valid), 64'd0);
    repeat (10) tick();
    check("t3_count", 64'(rsp_log.size()), 64'd1);
    check_rsp("t3", 0, 1'b1, 8'hFF, 32'h0, 1'b0);

    // Response back-pressure holds the response and blocks the next issue.
    rsp_log.delete();
    rsp_ready = 1'b0;
    push(1'b0, 8'hFF, 32'h0);
    push(1'b0, 8'h10, 32'h0);
    wait_rsp("t4_rsp");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_rvalid%0d", k), 64'(rsp_valid), 64'd1);
      check($sformatf("t4_raddr%0d", k),  64'(rsp_addr),  64'hFF);
      check($sformatf("t4_rdata%0d", k),  64'(rsp_rdata), 64'h1234_5678);
      check($sformatf("t4_nobus%0d", k),  64'(bus_valid), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t4_after1_rsp", 64'(rsp_valid), 64'd0);
    check("t4_after1_bus", 64'(bus_valid), 64'd0);
    tick();
    check("t4_after2_bus",  64'(bus_valid), 64'd1);
    check("t4_after2_addr", 64'(bus_addr),  64'h10);
    repeat (10) tick();
    check("t4_count", 64'(rsp_log.size()), 64'd2);
    check_rsp("t4_a", 0, 1'b0, 8'hFF, 32'h1234_5678, 1'b0);
    check_rsp("t4_b", 1, 1'b0, 8'h10, 32'hA5A5_0001, 1'b0);

    // Reset while a request is on the bus with two more queued.
    rsp_log.delete();
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 8'h40 + 8'(i), 32'h0);
    check("t5_pre_valid", 64'(bus_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus_valid), 64'd0);
    check("t5_rst_ready", 64'(cmd_ready), 64'd1);
    check("t5_rst_rsp",   64'(rsp_valid), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus_ready = 1'b1;
    repeat (20) tick();
    check("t5_no_rsp", 64'(rsp_log.size()), 64'd0);
    check("t5_idle",   64'(bus_valid),      64'd0);

`ifdef BUS_TIMEOUT_EN
    // Watchdog: slave never answers.
    begin
      int n = 0;
      rsp_log.delete();
      bus_ready = 1'b0;
      push(1'b0, 8'h20, 32'h0);
      wait_bus("t6_issue");
      while (bus_valid && n < 40) begin
        n++;
        tick();
      end
      check("t6_cycles", 64'(n), 64'd16);
      check("t6_rvalid", 64'(rsp_valid), 64'd1);
      check("t6_err",    64'(rsp_err),   64'd1);
      check("t6_addr",   64'(rsp_addr),  64'h20);
      check("t6_rdata",  64'(rsp_rdata), 64'd0);
      check("t6_wr",     64'(rsp_wr),    64'd0);
      bus_ready = 1'b1;
      repeat (5) tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
